bsram_copy_engine: RTL and testbench

- Bus initiator that drives the read and write ports of one BSRAM instance: block copy (memory-to-memory) or block fill (constant) of up to 2^ADDR_WIDTH words.
- Sits beside a core's data BSRAM. An arbiter hands it both BSRAM ports while busy is high.
- Relies on BSRAM's same-cycle combinational read and its write-to-read forwarding when addresses match.

---
 rtl/bsram_copy_engine.sv | 189 ++++++++++++++++++
 tb/tb_bsram_copy_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsram_copy_engine.sv
// BSRAM copy/fill engine: drives both ports of one BSRAM to copy a block
// (overlap-safe via direction choice) or fill it with a constant.
module bsram_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] srcAddress,
  input  logic [ADDR_WIDTH-1:0] dstAddress,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] fillData,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH:0]   wordsWritten,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData
);

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r, state_next_s;
  logic                    mode_r, desc_r, valid_r, abort_seen_r;
  logic                    busy_r, done_r, aborted_r;
  logic [ADDR_WIDTH-1:0]   src_r, dst_r, offset_r, waddr_r;
  logic [ADDR_WIDTH:0]     remain_r, words_r;
  logic [DATA_WIDTH-1:0]   fill_r, data_r;
  logic                    accept_s, step_s, last_s;

  // Command acceptance and per-cycle advance qualifiers
  always_comb begin
    accept_s = (state_r == IDLE) && start;
    step_s   = (state_r == RUN) && !abort;
    last_s   = (remain_r == CNT_ONE);
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = (length != CNT_ZERO) ? RUN : DONE;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (abort || last_s) state_next_s = mode_r ? DONE : DRAIN;
        else                 state_next_s = RUN;
      end
      DRAIN:   state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // BSRAM port drive; address/data are forced to zero whenever their enable is low
  always_comb begin
    readEnable   = 1'b0;
    readAddress  = ADDR_ZERO;
    writeEnable  = 1'b0;
    writeAddress = ADDR_ZERO;
    writeData    = DATA_ZERO;
    case (state_r)
      RUN: begin
        if (abort) begin
          readEnable = 1'b0;
        end else if (mode_r) begin
          writeEnable  = 1'b1;
          writeAddress = dst_r + offset_r;
          writeData    = fill_r;
        end else begin
          readEnable  = 1'b1;
          readAddress = src_r + offset_r;
          if (valid_r) begin
            writeEnable  = 1'b1;
            writeAddress = waddr_r;
            writeData    = data_r;
          end else begin
            writeEnable = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (valid_r) begin
          writeEnable  = 1'b1;
          writeAddress = waddr_r;
          writeData    = data_r;
        end else begin
          writeEnable = 1'b0;
        end
      end
      default: readEnable = 1'b0;
    endcase
  end

  // Command latch, offset walk and one-deep read-to-write data pipeline
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_r       <= 1'b0;
      desc_r       <= 1'b0;
      src_r        <= ADDR_ZERO;
      dst_r        <= ADDR_ZERO;
      fill_r       <= DATA_ZERO;
      offset_r     <= ADDR_ZERO;
      remain_r     <= CNT_ZERO;
      data_r       <= DATA_ZERO;
      waddr_r      <= ADDR_ZERO;
      valid_r      <= 1'b0;
      words_r      <= CNT_ZERO;
      abort_seen_r <= 1'b0;
    end else if (accept_s) begin
      mode_r       <= mode;
      desc_r       <= !mode && (dstAddress > srcAddress);
      src_r        <= srcAddress;
      dst_r        <= dstAddress;
      fill_r       <= fillData;
      offset_r     <= (!mode && (dstAddress > srcAddress)) ?
                      (length[ADDR_WIDTH-1:0] - ADDR_ONE) : ADDR_ZERO;
      remain_r     <= length;
      valid_r      <= 1'b0;
      words_r      <= CNT_ZERO;
      abort_seen_r <= 1'b0;
    end else begin
      if (step_s) begin
        offset_r <= desc_r ? (offset_r - ADDR_ONE) : (offset_r + ADDR_ONE);
        remain_r <= remain_r - CNT_ONE;
      end
      // An aborted cycle keeps the captured word so DRAIN can still write it
      if (step_s && !mode_r) begin
        data_r  <= readData;
        waddr_r <= dst_r + offset_r;
        valid_r <= 1'b1;
      end else if (state_r == DRAIN) begin
        valid_r <= 1'b0;
      end
      if (writeEnable)                abort_seen_r <= abort_seen_r;
      if (writeEnable)                words_r      <= words_r + CNT_ONE;
      if ((state_r == RUN) && abort)  abort_seen_r <= 1'b1;
    end
  end

  // Registered status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN) || (state_next_s == DRAIN);
      done_r <= (state_next_s == DONE);
      if (accept_s) begin
        aborted_r <= 1'b0;
      end else if ((state_next_s == DONE) &&
                   (abort_seen_r || ((state_r == RUN) && abort))) begin
        aborted_r <= 1'b1;
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign aborted      = aborted_r;
  assign wordsWritten = words_r;

endmodule

// File: tb/tb_bsram_copy_engine.sv
// Self-checking bench for bsram_copy_engine: behavioural BSRAM plus a
// block-level reference memory updated with whole-transfer semantics.
module tb_bsram_copy_engine;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clock = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [AW-1:0] srcAddress = '0, dstAddress = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] fillData = '0;
  logic          busy, done, aborted, readEnable, writeEnable;
  logic [AW:0]   wordsWritten;
  logic [AW-1:0] readAddress, writeAddress;
  logic [DW-1:0] readData, writeData;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  int            total_writes = 0;

  int n_checks = 0, n_pass = 0;
  int n_rd, n_wr, first_rd, last_rd, first_wr, last_wr, done_at, busy_cnt, leak;
  int ww_at_done, ab_at_done, post_done, post_busy, post_ab;

  bsram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .srcAddress(srcAddress), .dstAddress(dstAddress), .length(length),
    .fillData(fillData), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .wordsWritten(wordsWritten),
    .readEnable(readEnable), .readAddress(readAddress), .readData(readData),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData)
  );

  always #5 clock = ~clock;

  // BSRAM: combinational read with write-to-read forwarding
  assign readData = (writeEnable && (writeAddress == readAddress)) ? writeData : mem[readAddress];
  always @(posedge clock) begin
    if (writeEnable) begin
      mem[writeAddress] <= writeData;
      total_writes      <= total_writes + 1;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic poke(input int a, input logic [DW-1:0] v);
    @(negedge clock);
    poke_en = 1'b1; poke_addr = a[AW-1:0]; poke_data = v;
    ref_mem[a & 255] = v;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Whole-transfer reference: snapshot the source, then write `limit` words in issue order
  task automatic ref_apply(input logic m, input int s, input int d, input int len,
                           input logic [DW-1:0] fd, input int limit);
    logic [DW-1:0] tmp [256];
    bit desc;
    int k;
    desc = !m && (d > s);
    for (int j = 0; j < len; j++) tmp[j] = ref_mem[(s + j) & 255];
    for (int j = 0; j < limit; j++) begin
      k = desc ? (len - 1 - j) : j;
      ref_mem[(d + k) & 255] = m ? fd : tmp[k];
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic run_xfer(input logic m, input int s, input int d, input int len,
                          input logic [DW-1:0] fd, input int abort_at, input int restart_at);
    int rel;
    @(negedge clock);
    mode = m; srcAddress = s[AW-1:0]; dstAddress = d[AW-1:0];
    length = len[AW:0]; fillData = fd; start = 1'b1;
    rel = 0; n_rd = 0; n_wr = 0; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
    done_at = -1; busy_cnt = 0; leak = 0; ww_at_done = -1; ab_at_done = -1;
    while (done_at < 0 && rel < 600) begin
      @(negedge clock);
      rel++;
      start = (rel == restart_at);
      if (rel == restart_at) begin
        length = 9'd3; mode = ~m;
      end
      abort = (rel == abort_at);
      #1;
      if (readEnable) begin
        n_rd++; if (first_rd < 0) first_rd = rel; last_rd = rel;
        if (m) leak++;
      end else if (readAddress != '0) leak++;
      if (writeEnable) begin
        n_wr++; if (first_wr < 0) first_wr = rel; last_wr = rel;
      end else if (writeAddress != '0 || writeData != '0) leak++;
      if (busy) busy_cnt++;
      if (done) begin
        done_at = rel; ww_at_done = int'(wordsWritten); ab_at_done = int'(aborted);
        if (busy) leak++;
      end
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clock); #1;
    post_done = int'(done); post_busy = int'(busy); post_ab = int'(aborted);
  endtask

  task automatic expect_xfer(input string tag, input int e_rd, input int e_wr, input int e_fr,
                             input int e_lr, input int e_fw, input int e_lw, input int e_done,
                             input int e_busy, input int e_ab, input int e_ww);
    chk({tag, "/done_cycle"}, done_at, e_done);
    chk({tag, "/reads"}, n_rd, e_rd);
    chk({tag, "/writes"}, n_wr, e_wr);
    chk({tag, "/first_read"}, first_rd, e_fr);
    chk({tag, "/last_read"}, last_rd, e_lr);
    chk({tag, "/first_write"}, first_wr, e_fw);
    chk({tag, "/last_write"}, last_wr, e_lw);
    chk({tag, "/busy_cycles"}, busy_cnt, e_busy);
    chk({tag, "/words_written"}, ww_at_done, e_ww);
    chk({tag, "/aborted"}, ab_at_done, e_ab);
    chk({tag, "/aborted_held"}, post_ab, e_ab);
    chk({tag, "/done_one_cycle"}, post_done + post_busy, 0);
    chk({tag, "/port_rules"}, leak, 0);
    chk({tag, "/memory"}, mem_diffs(), 0);
  endtask

  task automatic expect_copy(input string tag, input int n);
    expect_xfer(tag, n, n, 1, n, 2, n + 1, n + 2, n + 1, 0, n);
  endtask

  task automatic expect_fill(input string tag, input int n);
    expect_xfer(tag, 0, n, -1, -1, 1, n, n + 1, n, 0, n);
  endtask

  initial begin
    int s, d, len, wr_before;
    logic m;
    logic [DW-1:0] fd;

    #2;
    chk("reset_outputs", {busy, done, aborted, readEnable, writeEnable, wordsWritten,
                          readAddress, writeAddress, writeData}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) poke(i, $urandom);

    // Non-overlapping copy
    for (int i = 0; i < 4; i++) poke(16 + i, 32'hA0 + i);
    run_xfer(1'b0, 16, 64, 4, 32'h0, -1, -1);
    ref_apply(1'b0, 16, 64, 4, 32'h0, 4);
    expect_copy("copy_basic", 4);
    chk("copy_basic/mem43", mem[67], 32'hA3);

    // Overlapping copies, forward then backward by one word
    for (int i = 0; i < 4; i++) poke(32 + i, i + 1);
    run_xfer(1'b0, 32, 33, 4, 32'h0, -1, -1);
    ref_apply(1'b0, 32, 33, 4, 32'h0, 4);
    expect_copy("overlap_desc", 4);
    chk("overlap_desc/mem", {mem[33][7:0], mem[34][7:0], mem[35][7:0], mem[36][7:0]}, 32'h01020304);
    run_xfer(1'b0, 33, 32, 4, 32'h0, -1, -1);
    ref_apply(1'b0, 33, 32, 4, 32'h0, 4);
    expect_copy("overlap_asc", 4);
    chk("overlap_asc/mem", {mem[32][7:0], mem[33][7:0], mem[34][7:0], mem[35][7:0]}, 32'h01020304);

    // Fill wrapping past the top address
    run_xfer(1'b1, 0, 254, 4, 32'hDEADBEEF, -1, -1);
    ref_apply(1'b1, 0, 254, 4, 32'hDEADBEEF, 4);
    expect_fill("fill_wrap", 4);
    chk("fill_wrap/mem01", mem[1], 32'hDEADBEEF);

    // Zero length, then a stray start during a busy copy
    run_xfer(1'b0, 5, 9, 0, 32'h0, -1, -1);
    expect_xfer("len0", 0, 0, -1, -1, -1, -1, 1, 0, 0, 0);
    run_xfer(1'b0, 80, 144, 8, 32'h0, -1, 3);
    ref_apply(1'b0, 80, 144, 8, 32'h0, 8);
    expect_copy("restart_ignored", 8);

    // Abort in the third RUN cycle of a descending copy
    run_xfer(1'b0, 128, 160, 8, 32'h0, 3, -1);
    ref_apply(1'b0, 128, 160, 8, 32'h0, 2);
    expect_xfer("abort", 2, 2, 1, 2, 2, 4, 5, 4, 1, 2);

    // Asynchronous reset in the middle of a copy
    @(negedge clock);
    mode = 1'b0; srcAddress = 8'h10; dstAddress = 8'h60; length = 9'd8; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_outputs", {busy, done, aborted, readEnable, writeEnable, wordsWritten,
                             readAddress, writeAddress, writeData}, 64'd0);
    wr_before = total_writes;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("midreset_no_writes", total_writes, wr_before);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    run_xfer(1'b0, 16, 96, 8, 32'h0, -1, -1);
    ref_apply(1'b0, 16, 96, 8, 32'h0, 8);
    expect_copy("after_reset", 8);

    // Randomised copies (some overlapping) and fills
    for (int it = 0; it < 8; it++) begin
      m   = $urandom_range(0, 1);
      len = $urandom_range(1, 40);
      s   = $urandom_range(0, 255 - len);
      if (it % 2 == 0) d = s + int'($urandom_range(0, 8)) - 4;
      else             d = $urandom_range(0, 255 - len);
      if (d < 0) d = 0;
      if (d > 255 - len) d = 255 - len;
      fd = $urandom;
      run_xfer(m, s, d, len, fd, -1, -1);
      ref_apply(m, s, d, len, fd, len);
      if (m) expect_fill("rand_fill", len);
      else   expect_copy("rand_copy", len);
    end

    // Full-size fill touches every word once
    run_xfer(1'b1, 0, 200, 256, 32'h5A5A1234, -1, -1);
    ref_apply(1'b1, 0, 200, 256, 32'h5A5A1234, 256);
    expect_fill("fill_full", 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
